// File: rtl/dma_ext_device.sv
// Buffers a 12-word block from a serial source, interrupts the CPU when full,
// and serves 64-bit chunks to the DMA until it signals completion.
module dma_ext_device #(
    parameter int WORD_SIZE   = 16,
    parameter int BLOCK_WORDS = 12,
    parameter int IRQ_RETRY   = 64
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [WORD_SIZE-1:0]   in_word,
    output logic                   in_ready,
    input  logic [1:0]             offset,
    output logic [4*WORD_SIZE-1:0] edata,
    input  logic                   dma_done,
    output logic                   dev_irq,
    output logic                   full
);

    localparam int RW = (IRQ_RETRY > 1) ? $clog2(IRQ_RETRY + 1) : 1;
    localparam bit RETRY_EN = (IRQ_RETRY != 0);
    localparam logic [RW-1:0] RETRY_LAST = RW'(IRQ_RETRY - 1);
    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [RW-1:0]        r_retry;
    logic                 r_irq;
    logic [WORD_SIZE-1:0] r_buf [BLOCK_WORDS];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_retry <= '0;
            r_irq   <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        r_buf[r_cnt] <= in_word;
                        if (r_cnt == LAST_WORD) begin
                            r_cnt   <= '0;
                            r_state <= S_FULL;
                            r_irq   <= 1'b1;
                            r_retry <= '0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (dma_done) begin
                        r_state <= S_FILL;
                        r_retry <= '0;
                    end else if (RETRY_EN && !r_irq) begin
                        // the pulse cycle itself is not counted
                        if (r_retry == RETRY_LAST) begin
                            r_irq   <= 1'b1;
                            r_retry <= '0;
                        end else begin
                            r_retry <= r_retry + 1'b1;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign in_ready = (r_state == S_FILL);
    assign full     = (r_state == S_FULL);
    assign dev_irq  = r_irq;

    always_comb begin
        edata = '0;
        case (offset)
            2'd0: edata = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
            2'd1: edata = {r_buf[7], r_buf[6], r_buf[5], r_buf[4]};
            2'd2: edata = {r_buf[11], r_buf[10], r_buf[9], r_buf[8]};
            default: edata = '0;
        endcase
    end

endmodule

// File: tb/tb_dma_ext_device.sv
// Scoreboard bench for dma_ext_device: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dma_ext_device;

    localparam int RETRY = 4;
    localparam int PER   = RETRY + 1;

    logic        CLK;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_word;
    logic        in_ready;
    logic [1:0]  offset;
    logic [63:0] edata;
    logic        dma_done;
    logic        dev_irq;
    logic        full;

    dma_ext_device #(
        .WORD_SIZE(16),
        .BLOCK_WORDS(12),
        .IRQ_RETRY(RETRY)
    ) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_word(in_word),
        .in_ready(in_ready),
        .offset(offset),
        .edata(edata),
        .dma_done(dma_done),
        .dev_irq(dev_irq),
        .full(full)
    );

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } probe_t;

    probe_t pq[$];
    int     irq_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    probe_t      m_p;
    logic [63:0] m_act;
    int          m_e;

    always @(negedge CLK) begin
        while (pq.size() > 0) begin
            m_p = pq.pop_front();
            case (m_p.kind)
                0: m_act = edata;
                1: m_act = {63'd0, full};
                default: m_act = {63'd0, in_ready};
            endcase
            n_cmp++;
            if (m_act !== m_p.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d)",
                         m_p.name, m_act, m_p.exp, cyc);
            end
        end
        if (dev_irq === 1'b1) begin
            n_cmp++;
            if (irq_q.size() == 0) begin
                n_bad++;
                $display("FAIL irq_unexpected: dev_irq at cycle %0d, none expected", cyc);
            end else begin
                m_e = irq_q.pop_front();
                if (m_e != cyc) begin
                    n_bad++;
                    $display("FAIL irq_timing: dev_irq at cycle %0d expected %0d", cyc, m_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_word  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk(input int k, input logic [63:0] e, input string nm);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        p.name = nm;
        pq.push_back(p);
    endtask

    task automatic chk_ed(input logic [1:0] off, input logic [63:0] e, input string nm);
        offset = off;
        chk(0, e, nm);
        tick();
    endtask

    task automatic expect_irqs(input int e0, input int m);
        for (int k = 0; PER * k <= m; k++) irq_q.push_back(e0 + PER * k);
    endtask

    task automatic release_at(input int t);
        if (cyc > t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL release_overrun: at cycle %0d expected <= %0d", cyc, t);
        end
        while (cyc < t) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] base, input bit gaps, output int e0);
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk(1, 64'd0, "full_before_last");
            send(base + 16'(i));
            if (gaps && i < 11) tick();
        end
        e0 = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        offset   = 2'd0;
        dma_done = 1'b0;
        tick();
        tick();
        chk(2, 64'd1, "rst_in_ready");
        chk(1, 64'd0, "rst_full");
        chk_ed(2'd0, 64'd0, "rst_edata0");
        reset_n = 1'b1;
        tick();

        // back-to-back block
        send_block(16'h0001, 1'b0, e0);
        expect_irqs(e0, 6);
        chk(1, 64'd1, "b2b_full");
        chk(2, 64'd0, "b2b_in_ready");
        chk_ed(2'd0, 64'h0004_0003_0002_0001, "b2b_off0");
        chk_ed(2'd1, 64'h0008_0007_0006_0005, "b2b_off1");
        chk_ed(2'd2, 64'h000C_000B_000A_0009, "b2b_off2");
        chk_ed(2'd3, 64'd0, "b2b_off3");
        release_at(e0 + 6);
        chk(2, 64'd1, "rel_in_ready");
        chk(1, 64'd0, "rel_full");
        chk_ed(2'd0, 64'h0004_0003_0002_0001, "stale_off0");

        // reset mid-block
        for (int i = 0; i < 7; i++) send(16'h0101 + 16'(i));
        reset_n = 1'b0;
        chk(2, 64'd1, "mid_rst_in_ready");
        chk(1, 64'd0, "mid_rst_full");
        chk_ed(2'd0, 64'd0, "mid_rst_off0");
        chk_ed(2'd1, 64'd0, "mid_rst_off1");
        reset_n = 1'b1;
        tick();

        // gapped block, then stalled source while full
        send_block(16'h0001, 1'b1, e0);
        expect_irqs(e0, 15);
        chk(1, 64'd1, "gap_full");
        chk_ed(2'd0, 64'h0004_0003_0002_0001, "gap_off0");
        chk_ed(2'd1, 64'h0008_0007_0006_0005, "gap_off1");
        chk_ed(2'd2, 64'h000C_000B_000A_0009, "gap_off2");
        in_valid = 1'b1;
        in_word  = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            chk(2, 64'd0, "stall_in_ready");
            tick();
        end
        chk_ed(2'd0, 64'h0004_0003_0002_0001, "stall_nowrite");
        release_at(e0 + 15);
        chk(2, 64'd1, "beef_in_ready");
        tick();
        in_valid = 1'b0;
        chk_ed(2'd0, 64'h0004_0003_0002_BEEF, "beef_written");

        // dma_done during fill is ignored
        for (int i = 0; i < 4; i++) send(16'h0021 + 16'(i));
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk(1, 64'd0, "fill_done_full");
        chk(2, 64'd1, "fill_done_in_ready");
        for (int i = 0; i < 7; i++) begin
            if (i == 6) chk(1, 64'd0, "fill_before_last");
            send(16'h0025 + 16'(i));
        end
        e0 = cyc;

        // retry pulses with no dma_done for 12 cycles
        expect_irqs(e0, 11);
        chk(1, 64'd1, "retry_full");
        chk_ed(2'd0, 64'h0023_0022_0021_BEEF, "retry_off0");
        chk_ed(2'd1, 64'h0027_0026_0025_0024, "retry_off1");
        chk_ed(2'd2, 64'h002B_002A_0029_0028, "retry_off2");
        release_at(e0 + 11);
        chk(2, 64'd1, "retry_rel_in_ready");

        // dma_done coinciding with the dev_irq cycle
        send_block(16'h0031, 1'b0, e0);
        expect_irqs(e0, 0);
        chk(1, 64'd1, "coinc_full");
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk(2, 64'd1, "coinc_in_ready");
        chk(1, 64'd0, "coinc_full_drop");
        chk_ed(2'd1, 64'h0038_0037_0036_0035, "coinc_off1");

        tick();
        tick();
        tick();
        n_cmp++;
        if (irq_q.size() != 0) begin
            n_bad++;
            $display("FAIL irq_missing: %0d expected pulses not seen, next at cycle %0d",
                     irq_q.size(), irq_q[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
